therm2bin_enc_4bit: RTL and testbench

- Registered 15-bit thermometer-to-4-bit binary encoder.
- Exact inverse of the team's 4-bit binary-to-thermometer decoder: 15'h0000 maps to 4'hF and 15'h7FFF maps to 4'h0.
- Sits on the readback side of the segmented DAC/flash path. Recovers the binary code from a thermometer word, flags non-thermometer (bubble) codes and keeps a saturating error count for debug.
- Two-stage pipeline with a valid qualifier.

---
 rtl/therm2bin_enc_4bit.sv | 155 +++++++++++++++
 tb/tb_therm2bin_enc_4bit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/therm2bin_enc_4bit.sv
// ---------------------------------------------------------------------------
// therm2bin_enc_4bit
//   Registered 15-bit thermometer to 4-bit binary encoder. It is the exact
//   inverse of the 4-bit binary-to-thermometer decoder: an all-zero word
//   encodes to 4'hF, and an all-ones word encodes to 4'h0. Words that are not
//   legal thermometer codes (bubbles) are flagged. A saturating counter
//   records those errors for debug.
//
//   Pipeline:
//     stage 1  captures therm_in on every edge; in_valid qualifies it
//     stage 2  encodes the captured word and drives the outputs
//   Latency is 2 edges. The block accepts one word per cycle and has no
//   back-pressure.
//
//   Optional build macro: THERM_BUBBLE_FIX_EN
//     When it is defined, the ones count is taken from a 3-tap
//     majority-filtered copy of the stage-1 word. The filter uses t[-1]=1 and
//     t[15]=0 at the edges. The filter sits inside stage 2, so latency does not
//     change. code_err and err_count always come from the raw word.
//
//   Parameters:
//     ERR_CNT_W   width of the saturating error counter (1..16)
//
//   Ports:
//     clk         clock; all state updates on posedge
//     resetb      synchronous active-low reset
//     therm_in    thermometer word; bit0 is the first segment to turn on
//     in_valid    therm_in is qualified this cycle
//     err_clr     synchronous clear of err_count (wins over an increment)
//     binary_out  encoded value, registered; held while no word is valid
//     out_valid   1-cycle pulse per accepted input
//     code_err    the word was not a legal thermometer code; qualified by
//                 out_valid
//     err_count   saturating count of code_err events
// ---------------------------------------------------------------------------

// Per-bit majority vote used by the bubble filter.
module therm2bin_maj_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_m
);
  assign o_m = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module therm2bin_enc_4bit #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic [14:0]          therm_in,
  input  logic                 in_valid,
  input  logic                 err_clr,
  output logic [3:0]           binary_out,
  output logic                 out_valid,
  output logic                 code_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int TW     = 15;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [3:0] bin;
    logic       err;
  } s2_res_t;

  // State
  logic [TW-1:0]        r_s1_data;
  logic [STAGES:1]      r_vld_pipe;
  s2_res_t              r_s2;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Stage-2 combinational
  logic [TW-1:0]        w_src;
  logic                 w_bubble;
  logic [3:0]           w_ones;
  logic                 w_err_inc;

`ifdef THERM_BUBBLE_FIX_EN
  // Extended word: index 0 is t[-1]=1 and index TW+1 is t[15]=0. Tap gi+1 is
  // the centre bit.
  logic [TW+1:0] w_ext;
  assign w_ext = {1'b0, r_s1_data, 1'b1};

  generate
    for (genvar gi = 0; gi < TW; gi++) begin : g_maj
      therm2bin_maj_cell u_maj (
        .i_a (w_ext[gi]),
        .i_b (w_ext[gi+1]),
        .i_c (w_ext[gi+2]),
        .o_m (w_src[gi])
      );
    end
  endgenerate
`else
  assign w_src = r_s1_data;
`endif

  // A legal thermometer word never has a set bit above a clear bit. That
  // check is the same as comparing the word with (1<<popcount)-1, but it does
  // not need a second ones count.
  assign w_bubble = |(r_s1_data[TW-1:1] & ~r_s1_data[TW-2:0]);

  // Ones count of the encoder source. The range is 0..15, so it fits in 4 bits.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < TW; i++)
      w_ones = w_ones + {3'b000, w_src[i]};
  end

  assign w_err_inc = r_vld_pipe[1] & w_bubble;

  // Stage 1: the data is captured unconditionally, and the valid bit
  // qualifies it.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_s1_data  <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_s1_data  <= therm_in;
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
    end
  end

  // Stage 2: binary_out holds while no word is valid. code_err is a pulse.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_s2.bin <= 4'hF;
      r_s2.err <= 1'b0;
    end else if (r_vld_pipe[1]) begin
      r_s2.bin <= 4'd15 - w_ones;
      r_s2.err <= w_bubble;
    end else begin
      r_s2.err <= 1'b0;
    end
  end

  // The counter steps on the same edge that presents the error. A clear
  // takes priority over the increment, and the counter stops at all-ones.
  always_ff @(posedge clk) begin
    if (!resetb)
      r_err_cnt <= '0;
    else if (err_clr)
      r_err_cnt <= '0;
    else if (w_err_inc && (r_err_cnt != {ERR_CNT_W{1'b1}}))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign binary_out = r_s2.bin;
  assign code_err   = r_s2.err;
  assign out_valid  = r_vld_pipe[STAGES];
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_therm2bin_enc_4bit.sv
module tb_therm2bin_enc_4bit;
  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [14:0] therm_in = '0;
  logic        in_valid = 1'b0;
  logic        err_clr = 1'b0;

  logic [3:0]  binary_out, binary_out_s;
  logic        out_valid, out_valid_s;
  logic        code_err, code_err_s;
  logic [7:0]  err_count;
  logic [1:0]  err_count_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  therm2bin_enc_4bit #(.ERR_CNT_W(8)) dut (
    .clk(clk), .resetb(resetb), .therm_in(therm_in), .in_valid(in_valid),
    .err_clr(err_clr), .binary_out(binary_out), .out_valid(out_valid),
    .code_err(code_err), .err_count(err_count)
  );

  therm2bin_enc_4bit #(.ERR_CNT_W(2)) dut_s (
    .clk(clk), .resetb(resetb), .therm_in(therm_in), .in_valid(in_valid),
    .err_clr(err_clr), .binary_out(binary_out_s), .out_valid(out_valid_s),
    .code_err(code_err_s), .err_count(err_count_s)
  );

  // Reference model. Each output follows from the input accepted two edges
  // earlier, so the model keeps a two-deep history of the sampled inputs.
  logic [14:0] h_data [2];
  logic        h_vld  [2];
  logic        m_vld;
  logic [3:0]  m_bin;
  logic        m_err;
  int          m_cnt8, m_cnt2;

  function automatic int ones(input logic [14:0] t);
    int n = 0;
    for (int i = 0; i < 15; i++) n += int'(t[i]);
    return n;
  endfunction

  function automatic int src_ones(input logic [14:0] t);
`ifdef THERM_BUBBLE_FIX_EN
    int n = 0;
    logic [16:0] e;
    e = {1'b0, t, 1'b1};
    for (int i = 0; i < 15; i++)
      if (int'(e[i]) + int'(e[i+1]) + int'(e[i+2]) >= 2) n++;
    return n;
`else
    return ones(t);
`endif
  endfunction

  function automatic logic is_bad(input logic [14:0] t);
    int p = ones(t);
    logic [15:0] legal = (16'd1 << p) - 16'd1;
    return {1'b0, t} != legal;
  endfunction

  task automatic model_edge(input logic [14:0] t, input logic v, input logic c, input logic r);
    logic s1v;
    logic [14:0] s1d;
    s1v = h_vld[0];
    s1d = h_data[0];
    if (!r) begin
      m_vld = 0; m_bin = 4'hF; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
      h_vld[0] = 0; h_data[0] = '0;
    end else begin
      m_vld = s1v;
      m_err = s1v && is_bad(s1d);
      if (s1v) m_bin = 4'(15 - src_ones(s1d));
      if (c) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (m_err) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      h_vld[0] = v; h_data[0] = t;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", int'(out_valid), int'(m_vld));
    chk("binary_out", int'(binary_out), int'(m_bin));
    chk("code_err", int'(code_err), int'(m_err));
    chk("err_count", int'(err_count), m_cnt8);
    chk("out_valid_s", int'(out_valid_s), int'(m_vld));
    chk("binary_out_s", int'(binary_out_s), int'(m_bin));
    chk("err_count_s", int'(err_count_s), m_cnt2);
  endtask

  task automatic step(input logic [14:0] t, input logic v, input logic c, input logic r);
    therm_in = t; in_valid = v; err_clr = c; resetb = r;
    @(posedge clk);
    #1;
    model_edge(t, v, c, r);
    compare();
  endtask

  task automatic clear_cnt();
    step(15'h0, 0, 1, 1);
    step(15'h0, 0, 1, 1);
    step(15'h0, 0, 1, 1);
  endtask

  logic [14:0] rt;
  int          sel;

  initial begin
    h_vld[0] = 0; h_vld[1] = 0; h_data[0] = '0; h_data[1] = '0;
    m_vld = 0; m_bin = 4'hF; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;

    // Reset: 3 edges held low while valid all-ones words are presented.
    for (int i = 0; i < 3; i++) step(15'h7FFF, 1, 0, 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_binary", int'(binary_out), 15);
    chk("rst_err_count", int'(err_count), 0);
    // First output comes 2 edges after the first valid sample.
    step(15'h0001, 1, 0, 1);
    chk("lat_edge1_valid", int'(out_valid), 0);
    step(15'h0000, 0, 0, 1);
    chk("lat_edge2_valid", int'(out_valid), 1);
    chk("lat_edge2_bin", int'(binary_out), 14);
    step(15'h0000, 0, 0, 1);

    // Legal sweep, back to back.
    for (int k = 0; k <= 16; k++) begin
      rt = 15'((32'd1 << k) - 32'd1);
      step(rt, k <= 15, 0, 1);
      if (k >= 1) begin
        chk("sweep_valid", int'(out_valid), 1);
        chk("sweep_bin", int'(binary_out), 15 - (k - 1));
        chk("sweep_err", int'(code_err), 0);
      end
    end
    step(15'h0, 0, 0, 1);

    // Bubble word.
    clear_cnt();
    step(15'h7FFD, 1, 0, 1);
    step(15'h0, 0, 0, 1);
    chk("bubble_err", int'(code_err), 1);
    chk("bubble_cnt", int'(err_count), 1);
`ifdef THERM_BUBBLE_FIX_EN
    chk("bubble_bin", int'(binary_out), 0);
`else
    chk("bubble_bin", int'(binary_out), 1);
`endif

    // Saturation of the 2-bit counter.
    clear_cnt();
    for (int i = 0; i < 8; i++) begin
      step(15'h0002, i < 6, 0, 1);
      if (i >= 1 && i <= 6) begin
        chk("sat_cnt", int'(err_count_s), (i < 3) ? i : 3);
        chk("sat_bin", int'(binary_out_s), 14);
      end
    end

    // Clear collides with the edge that presents an error.
    clear_cnt();
    step(15'h0002, 1, 0, 1);
    step(15'h0000, 0, 1, 1);
    chk("clr_col_err", int'(code_err), 1);
    chk("clr_col_cnt", int'(err_count), 0);
    step(15'h0002, 1, 0, 1);
    step(15'h0000, 0, 0, 1);
    chk("clr_next_cnt", int'(err_count), 1);

    // Valid gaps. Data captured while in_valid is low must be ignored.
    step(15'h0003, 1, 0, 1);
    step(15'h5A5A, 0, 0, 1);
    chk("gap_v1", int'(out_valid), 1);
    chk("gap_b1", int'(binary_out), 13);
    step(15'h000F, 1, 0, 1);
    chk("gap_v0", int'(out_valid), 0);
    chk("gap_b0", int'(binary_out), 13);
    step(15'h0, 0, 0, 1);
    chk("gap_v2", int'(out_valid), 1);
    chk("gap_b2", int'(binary_out), 11);

    // Reset in the middle of a stream discards the words in flight.
    step(15'h0007, 1, 0, 1);
    step(15'h0003, 1, 0, 0);
    step(15'h0000, 0, 0, 1);
    chk("midrst_v", int'(out_valid), 0);
    step(15'h0000, 0, 0, 1);
    chk("midrst_v2", int'(out_valid), 0);

    // Randomized traffic: legal codes, single-bit corruptions and raw noise.
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 3));
      rt = 15'((32'd1 << $urandom_range(0, 15)) - 32'd1);
      if (sel == 1) rt = rt ^ 15'(32'd1 << $urandom_range(0, 14));
      else if (sel >= 2) rt = 15'($urandom);
      step(rt, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
